// File: rtl/font_req_initiator.sv
`default_nettype none
// ============================================================================
// font_req_initiator : requesting end of the font to_hw/to_sw sig/port pair.
// Optional macro FONT_REQ_STATS_EN adds stat_ok/stat_err.      Rev 1.0
// ============================================================================
module font_req_initiator #(
  parameter int unsigned DATA_DLY = 2,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  input  logic [29:0] req_word,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [29:0] resp_data,
  output logic        resp_err,
  output logic [2:0]  to_hw_sig_font,
  output logic [29:0] to_hw_port_font,
  input  logic [2:0]  to_sw_sig_font,
  input  logic [29:0] to_sw_port_font
`ifdef FONT_REQ_STATS_EN
  ,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err
`endif
);

  localparam logic [2:0]  HW_IDLE     = 3'd0;
  localparam logic [2:0]  HW_START    = 3'd5;
  localparam logic [2:0]  HW_RELEASE  = 3'd6;
  localparam logic [2:0]  SW_WAIT     = 3'd0;
  localparam logic [2:0]  SW_RETRIEVE = 3'd1;
  localparam logic [2:0]  SW_RESET    = 3'd3;
  localparam logic [15:0] TIMEOUT_M1  = 16'(TIMEOUT - 1);
  localparam logic [15:0] DLY_M1      = 16'(DATA_DLY - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_IDLE   = 3'd1,
    S_REQ    = 3'd2,
    S_SETTLE = 3'd3,
    S_REL    = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] timer_inc;
  logic [29:0] port_q, port_d;
  logic [29:0] data_q, data_d;
  logic        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    port_d    = port_q;
    data_d    = data_q;
    err_d     = err_q;
    timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    case (state_q)
      S_RESET: begin
        if (to_sw_sig_font == SW_WAIT) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          port_d  = req_word;
          data_d  = '0;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = S_REQ;
        end else if (to_sw_sig_font == SW_RESET) begin
          state_d = S_RESET;
        end
      end
      S_REQ: begin
        if (to_sw_sig_font == SW_RESET) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_RESP;
        end else if (to_sw_sig_font == SW_RETRIEVE) begin
          timer_d = '0;
          state_d = S_SETTLE;
        end else if (timer_q == TIMEOUT_M1) begin
          // Still release the responder so it can return to its wait state.
          err_d   = 1'b1;
          data_d  = '0;
          timer_d = '0;
          state_d = S_REL;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_SETTLE: begin
        if (to_sw_sig_font == SW_RESET) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_RESP;
        end else if (timer_q == DLY_M1) begin
          data_d  = to_sw_port_font;
          timer_d = '0;
          state_d = S_REL;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_REL: begin
        if (to_sw_sig_font == SW_RESET) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_RESP;
        end else if (to_sw_sig_font == SW_WAIT) begin
          state_d = S_RESP;
        end else if (timer_q == TIMEOUT_M1) begin
          err_d   = 1'b1;
          data_d  = '0;
          state_d = S_RESP;
        end else begin
          timer_d = timer_inc;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_RESET;
      timer_q <= '0;
      port_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      port_q  <= port_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready       = (state_q == S_IDLE);
    resp_valid      = (state_q == S_RESP);
    resp_data       = resp_valid ? data_q : '0;
    resp_err        = resp_valid & err_q;
    to_hw_port_font = port_q;
    case (state_q)
      S_REQ, S_SETTLE: to_hw_sig_font = HW_START;
      S_REL:           to_hw_sig_font = HW_RELEASE;
      default:         to_hw_sig_font = HW_IDLE;
    endcase
  end

`ifdef FONT_REQ_STATS_EN
  logic [15:0] stat_ok_q, stat_ok_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_ok_d  = stat_ok_q;
    stat_err_d = stat_err_q;
    if (resp_valid && resp_ready) begin
      if (err_q) begin
        if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      end else begin
        if (stat_ok_q != 16'hFFFF) stat_ok_d = stat_ok_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      stat_ok_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ok_q  <= stat_ok_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ok  = stat_ok_q;
  assign stat_err = stat_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_font_req_initiator.sv
`default_nettype none
// Directed bench for font_req_initiator with a per-cycle transaction-level model.
module tb_font_req_initiator;
  localparam int unsigned DATA_DLY = 2;
  localparam int unsigned TIMEOUT  = 8;
  localparam int PH_RESET = 0, PH_IDLE = 1, PH_REQ = 2, PH_SETTLE = 3, PH_REL = 4, PH_RESP = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [29:0] req_word;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [29:0] resp_data;
  logic        resp_err;
  logic [2:0]  hw_sig;
  logic [29:0] hw_port;
  logic [2:0]  sw_sig;
  logic [29:0] sw_port;
`ifdef FONT_REQ_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  font_req_initiator #(.DATA_DLY(DATA_DLY), .TIMEOUT(TIMEOUT)) dut (
    .Clk            (clk),
    .Reset_n        (rst_n),
    .req_valid      (req_valid),
    .req_word       (req_word),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .to_hw_sig_font (hw_sig),
    .to_hw_port_font(hw_port),
    .to_sw_sig_font (sw_sig),
    .to_sw_port_font(sw_port)
`ifdef FONT_REQ_STATS_EN
    ,
    .stat_ok        (stat_ok),
    .stat_err       (stat_err)
`endif
  );

  // Transaction model: phase plus cycles spent in it, updated from the inputs seen at each edge.
  int          m_phase = PH_RESET;
  int          m_cnt = 0;
  logic [29:0] m_word = '0;
  logic [29:0] m_data = '0;
  logic        m_err = 1'b0;
  int          m_ok = 0;
  int          m_bad = 0;
  bit          m_started = 0;

  always @(posedge clk) begin
    m_started = 1;
    if (!rst_n) begin
      m_phase = PH_RESET; m_cnt = 0; m_word = '0; m_data = '0; m_err = 1'b0;
      m_ok = 0; m_bad = 0;
    end else begin
      case (m_phase)
        PH_RESET: if (sw_sig == 3'd0) m_phase = PH_IDLE;
        PH_IDLE: begin
          if (req_valid) begin
            m_word = req_word; m_data = '0; m_err = 1'b0; m_cnt = 0; m_phase = PH_REQ;
          end else if (sw_sig == 3'd3) begin
            m_phase = PH_RESET;
          end
        end
        PH_REQ, PH_SETTLE, PH_REL: begin
          m_cnt++;
          if (sw_sig == 3'd3) begin
            m_err = 1'b1; m_data = '0; m_phase = PH_RESP;
          end else if (m_phase == PH_REQ && sw_sig == 3'd1) begin
            m_cnt = 0; m_phase = PH_SETTLE;
          end else if (m_phase == PH_SETTLE && m_cnt == int'(DATA_DLY)) begin
            m_data = sw_port; m_cnt = 0; m_phase = PH_REL;
          end else if (m_phase == PH_REL && sw_sig == 3'd0) begin
            m_phase = PH_RESP;
          end else if (m_phase != PH_SETTLE && m_cnt == int'(TIMEOUT)) begin
            m_err = 1'b1; m_data = '0; m_cnt = 0;
            m_phase = (m_phase == PH_REQ) ? PH_REL : PH_RESP;
          end
        end
        PH_RESP: begin
          if (resp_ready) begin
            if (m_err) m_bad = (m_bad < 65535) ? m_bad + 1 : m_bad;
            else       m_ok  = (m_ok  < 65535) ? m_ok + 1  : m_ok;
            m_phase = PH_IDLE;
          end
        end
        default: m_phase = PH_RESET;
      endcase
    end
  end

  logic [65:0] cmp_act, cmp_exp;
  logic [2:0]  exp_sig;

  always @(negedge clk) begin
    if (m_started) begin
      exp_sig = (m_phase == PH_REQ || m_phase == PH_SETTLE) ? 3'd5 :
                (m_phase == PH_REL) ? 3'd6 : 3'd0;
      cmp_act = {req_ready, resp_valid, resp_data, resp_err, hw_sig, hw_port};
      cmp_exp = {(m_phase == PH_IDLE), (m_phase == PH_RESP),
                 (m_phase == PH_RESP) ? m_data : 30'd0,
                 (m_phase == PH_RESP) & m_err, exp_sig, m_word};
      checks++;
      if (cmp_act !== cmp_exp) begin
        errors++;
        $display("FAIL model_outputs t=%0t got %h expected %h", $time, cmp_act, cmp_exp);
      end
`ifdef FONT_REQ_STATS_EN
      checks++;
      if ({stat_ok, stat_err} !== {16'(m_ok), 16'(m_bad)}) begin
        errors++;
        $display("FAIL model_stats t=%0t got %0d/%0d expected %0d/%0d", $time,
                 stat_ok, stat_err, m_ok, m_bad);
      end
`endif
    end
  end

  // Records each change of to_hw_sig_font while enabled.
  bit         trk = 0;
  logic [2:0] last_sig = 3'd0;
  logic [2:0] trace[$];
  always @(negedge clk) begin
    if (trk && hw_sig !== last_sig) begin
      trace.push_back(hw_sig);
      last_sig = hw_sig;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_resp(input string nm);
    int n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin tick(1); n++; end
    check(nm, resp_valid, 1);
  endtask

  task automatic release_wait(input string nm);
    int n = 0;
    while (hw_sig !== 3'd6 && n < 100) begin tick(1); n++; end
    check(nm, hw_sig, 6);
    sw_sig = 3'd0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick(1);
    resp_ready = 1'b0;
  endtask

  task automatic issue(input logic [29:0] w);
    req_valid = 1'b1;
    req_word  = w;
    tick(1);
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_word = '0; resp_ready = 1'b0;
    sw_sig = 3'd3; sw_port = '0;
    tick(3);
    check("reset_outputs", {req_ready, resp_valid, resp_data, resp_err, hw_sig, hw_port}, 0);
    rst_n = 1'b1;
    tick(2);
    check("responder_in_reset", req_ready, 0);
    sw_sig = 3'd0;
    tick(1);
    check("idle_ready", req_ready, 1);

    // Normal transaction, responder acks after two cycles.
    trace.delete(); last_sig = 3'd0; trk = 1;
    issue(30'h0ABCDEF);
    check("port_latched", hw_port, 30'h0ABCDEF);
    tick(2);
    sw_sig = 3'd1; sw_port = 30'h1234567;
    release_wait("good_release");
    wait_resp("good_resp");
    check("good_data", resp_data, 30'h1234567);
    check("good_err", resp_err, 0);
    handshake();
    trk = 0;
    check("sig_seq_len", trace.size(), 3);
    check("sig_seq", {trace[0], trace[1], trace[2]}, {3'd5, 3'd6, 3'd0});

    // Responder never acks: REQ times out after TIMEOUT cycles.
    issue(30'h3000001);
    n = 0;
    while (hw_sig == 3'd5 && n < 50) begin n++; tick(1); end
    check("req_timeout_len", n, TIMEOUT);
    check("rel_after_timeout", hw_sig, 6);
    wait_resp("timeout_resp");
    check("timeout_resp_fields", {resp_err, resp_data}, {1'b1, 30'd0});
    handshake();

    // Responder reset during SETTLE.
    issue(30'h0000F0F);
    sw_sig = 3'd1; sw_port = 30'h3FFFFFFF;
    tick(1);
    sw_sig = 3'd3;
    tick(1);
    check("abort_resp", {resp_valid, resp_err, resp_data, hw_sig}, {1'b1, 1'b1, 30'd0, 3'd0});
    handshake();
    check("abort_idle", req_ready, 1);
    tick(1);
    check("abort_to_reset", req_ready, 0);
    sw_sig = 3'd0;
    tick(1);
    check("recover_idle", req_ready, 1);

    // Response held for 10 cycles while a new request waits.
    issue(30'h0C0FFEE);
    sw_sig = 3'd1; sw_port = 30'h15555555;
    release_wait("stall_release");
    wait_resp("stall_resp");
    req_valid = 1'b1; req_word = 30'h2222222;
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", {resp_valid, req_ready, resp_err, resp_data, hw_port},
            {1'b1, 1'b0, 1'b0, 30'h15555555, 30'h0C0FFEE});
      tick(1);
    end
    req_valid = 1'b0;
    handshake();

    // Responder stuck at retrieve: REL times out.
    issue(30'h0777777);
    sw_sig = 3'd1; sw_port = 30'h0ABCABC;
    n = 0;
    while (hw_sig !== 3'd6 && n < 50) begin n++; tick(1); end
    n = 0;
    while (hw_sig == 3'd6 && n < 50) begin n++; tick(1); end
    check("rel_timeout_len", n, TIMEOUT);
    check("rel_timeout_resp", {resp_valid, resp_err, resp_data}, {1'b1, 1'b1, 30'd0});
    sw_sig = 3'd0;
    handshake();

    // Immediate responder: accept cycle to resp_valid is DATA_DLY + 3 cycles.
    sw_sig = 3'd1; sw_port = 30'h0246813;
    req_valid = 1'b1; req_word = 30'h1111111;
    n = 0;
    while (resp_valid !== 1'b1 && n < 50) begin
      tick(1); n++;
      if (n == 1) req_valid = 1'b0;
      if (hw_sig == 3'd6) sw_sig = 3'd0;
    end
    check("min_latency", n, DATA_DLY + 3);
    check("latency_data", {resp_err, resp_data}, {1'b0, 30'h0246813});
    handshake();

`ifdef FONT_REQ_STATS_EN
    // Three clean and three errored responses so far.
    check("stat_ok", stat_ok, 3);
    check("stat_err", stat_err, 3);
`endif

    // Reset mid-transaction discards it.
    issue(30'h0123456);
    tick(2);
    rst_n = 1'b0; sw_sig = 3'd3;
    tick(2);
    check("midtxn_reset", {req_ready, resp_valid, resp_data, resp_err, hw_sig, hw_port}, 0);
    rst_n = 1'b1; sw_sig = 3'd0;
    tick(2);
    check("post_reset_idle", {req_ready, resp_valid}, {1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
